reg_en_4b: RTL and testbench

//   4-bit D register with write enable and asynchronous active-high reset.

---
 rtl/reg_pkg.sv | 8 +
 rtl/reg_en_bit.sv | 23 ++
 rtl/reg_en_4b.sv | 39 +++
 tb/tb_reg_en_4b.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared width constant and data type for the small enable-register family.
package reg_pkg;

    localparam int REG_W = 4;

    typedef logic [REG_W-1:0] reg_data_t;

endpackage : reg_pkg

// File: rtl/reg_en_bit.sv
// Single-bit flop with write enable and asynchronous active-high reset to RST_BIT.
module reg_en_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    // Storage flop: reset dominates, otherwise load on enable or hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_BIT;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule : reg_en_bit

// File: rtl/reg_en_4b.sv
// WIDTH-bit enable register built from per-bit flops; optional X-checks under REG_EN_4B_XCHECK_EN.
module reg_en_4b
    import reg_pkg::*;
#(
    parameter int                WIDTH     = REG_W,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        reg_en_bit #(
            .RST_BIT (RESET_VAL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .d     (d[i]),
            .q     (q[i])
        );
    end

`ifdef REG_EN_4B_XCHECK_EN
    // Unknown control or loaded data would silently corrupt stored state.
    a_en_known : assert property (@(posedge clk) disable iff (reset)
        !$isunknown(en));

    a_d_known : assert property (@(posedge clk) disable iff (reset)
        (en === 1'b1) |-> !$isunknown(d));

    a_q_reset : assert property (@(posedge clk)
        (reset === 1'b1) |-> (q === RESET_VAL));
`endif

endmodule : reg_en_4b

// File: tb/tb_reg_en_4b.sv
// Directed self-checking bench for reg_en_4b with hand-computed expectations.
module tb_reg_en_4b;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] d;
    logic [3:0] q;

    int pass_cnt;
    int total_cnt;

    reg_en_4b dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (d),
        .q     (q)
    );

    // One full clock period, ending with clk low; samples are taken afterwards.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clk = 1'b0; d = 4'h0; en = 1'b0; reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (q !== 4'h0) $display("FAIL reset_async q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
        en = 1'b1; d = 4'hF;
        tick();
        total_cnt++;
        if (q !== 4'h0) $display("FAIL reset_hold_clk q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
        en = 1'b0; d = 4'h0;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (q !== 4'h0) $display("FAIL reset_release q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (q !== 4'h0) $display("FAIL reset_release_edge q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
    endtask

    task automatic test_store_one();
        en = 1'b1; d = 4'h1;
        #1;
        total_cnt++;
        if (q !== 4'h0) $display("FAIL store_one_pre_edge q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (q !== 4'h1) $display("FAIL store_one q=%h expected=%h", q, 4'h1);
        else pass_cnt++;
        en = 1'b0; d = 4'h0;
        #2;
        total_cnt++;
        if (q !== 4'h1) $display("FAIL store_one_hold_low q=%h expected=%h", q, 4'h1);
        else pass_cnt++;
    endtask

    task automatic test_store_zero();
        en = 1'b1; d = 4'h0;
        tick();
        total_cnt++;
        if (q !== 4'h0) $display("FAIL store_zero q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
    endtask

    task automatic test_enable_low();
        en = 1'b0; d = 4'h1;
        tick();
        total_cnt++;
        if (q !== 4'h0) $display("FAIL en_low_d1 q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
        d = 4'h0;
        tick();
        total_cnt++;
        if (q !== 4'h0) $display("FAIL en_low_d0 q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
    endtask

    task automatic test_full_width();
        en = 1'b1; d = 4'hF;
        tick();
        total_cnt++;
        if (q !== 4'hF) $display("FAIL full_F q=%h expected=%h", q, 4'hF);
        else pass_cnt++;
        d = 4'hA;
        tick();
        total_cnt++;
        if (q !== 4'hA) $display("FAIL full_A q=%h expected=%h", q, 4'hA);
        else pass_cnt++;
        en = 1'b0; d = 4'h5;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (q !== 4'hA) $display("FAIL hold_A_%0d q=%h expected=%h", i, q, 4'hA);
            else pass_cnt++;
        end
        // Toggle d and en while clk is steady high: no edge, so no change.
        #5 clk = 1'b1;
        #1 d = 4'h3; en = 1'b1;
        #1;
        total_cnt++;
        if (q !== 4'hA) $display("FAIL no_comb_path q=%h expected=%h", q, 4'hA);
        else pass_cnt++;
        en = 1'b0;
        #3 clk = 1'b0;
        #1;
    endtask

    task automatic test_async_reset();
        #4 clk = 1'b1;
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if (q !== 4'h0) $display("FAIL async_mid q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
        #3 clk = 1'b0;
        en = 1'b1; d = 4'hF;
        tick();
        total_cnt++;
        if (q !== 4'h0) $display("FAIL reset_beats_en q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
        en = 1'b0;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (q !== 4'h0) $display("FAIL async_release q=%h expected=%h", q, 4'h0);
        else pass_cnt++;
        en = 1'b1; d = 4'h6;
        tick();
        total_cnt++;
        if (q !== 4'h6) $display("FAIL load_after_reset q=%h expected=%h", q, 4'h6);
        else pass_cnt++;
    endtask

    // Sequence all scenarios, then print the summary.
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_store_one();
        test_store_zero();
        test_enable_low();
        test_full_width();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_reg_en_4b
